onehot8_encoder: RTL and testbench

Registered 8-to-3 re-encoder and integrity monitor that sits directly downstream of the 3-to-8 decoder. It consumes the eight decoder lines `y0`..`y7` and accepts a pattern only after it has been stable for a configurable number of samples. It then regenerates the 3-bit select `a`,`b`,`c` (`a` = MSB) and flags any pattern that is not one-hot. Its purpose is loop-back checking of the decoder in-system and on the bench.

---
 rtl/onehot8_encoder.sv | 129 ++++++++++++
 tb/tb_onehot8_encoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/onehot8_encoder.sv
// Registered 8-to-3 re-encoder with stability filter and one-hot integrity check.
// Optional error counter is built only when ONEHOT8_ERR_CNT_EN is defined.
module onehot8_encoder #(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    input  logic             y4,
    input  logic             y5,
    input  logic             y6,
    input  logic             y7,
    input  logic             sample_en,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             code_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, FAULT} state_t;

    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  w_y;
    logic [7:0]  r_cand;
    logic [7:0]  w_cand_nxt;
    logic [3:0]  r_run;
    logic [3:0]  w_run_nxt;
    logic        w_accept;
    logic        w_is_onehot;
    logic [2:0]  w_index;
    logic [2:0]  r_code;
    logic        r_code_valid;
    logic        r_err;

    assign w_y         = {y7, y6, y5, y4, y3, y2, y1, y0};
    assign w_is_onehot = (w_y != 8'd0) && ((w_y & (w_y - 8'd1)) == 8'd0);

    always_comb begin
        w_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_y[i]) w_index = 3'(i);
        end
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_run_nxt   = r_run;
        w_accept    = 1'b0;
        if (sample_en) begin
            if (w_y == 8'd0) begin
                w_state_nxt = IDLE;
                w_run_nxt   = 4'd0;
            end else if (r_state != IDLE && w_y == r_cand) begin
                // LOCKED and FAULT simply hold on a repeat; only SETTLE keeps counting.
                if (r_state == SETTLE) begin
                    w_run_nxt = r_run + 4'd1;
                    if (r_run + 4'd1 == STABLE_N) w_accept = 1'b1;
                end
            end else begin
                w_cand_nxt  = w_y;
                w_run_nxt   = 4'd1;
                w_state_nxt = SETTLE;
                if (STABLE_N == 4'd1) w_accept = 1'b1;
            end
            if (w_accept) w_state_nxt = w_is_onehot ? LOCKED : FAULT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cand  <= 8'd0;
            r_run   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_run   <= w_run_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code       <= 3'd0;
            r_code_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_code_valid <= w_accept && w_is_onehot;
            r_err        <= w_accept && !w_is_onehot;
            if (w_accept && w_is_onehot) r_code <= w_index;
        end
    end

`ifdef ONEHOT8_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_is_onehot && r_err_cnt != {CNT_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign a          = r_code[2];
    assign b          = r_code[1];
    assign c          = r_code[0];
    assign code_valid = r_code_valid;
    assign err        = r_err;
    assign locked     = (r_state == LOCKED);

endmodule

// File: tb/tb_onehot8_encoder.sv
// Randomized and directed bench for onehot8_encoder against a run-length reference model.
// Counter expectations follow ONEHOT8_ERR_CNT_EN when the bench is built with it.
module tb_onehot8_encoder;

    localparam int N     = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ONEHOT8_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       y = 8'd0;
    logic             sample_en = 1'b0;
    logic             a, b, c, code_valid, locked, err;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: length of the current run of identical non-zero samples.
    int         m_run = 0;
    logic [7:0] m_prev = 8'd0;
    logic [2:0] m_abc = 3'd0;
    bit         m_cv = 0, m_err = 0, m_locked = 0;
    int         m_cnt = 0;
    int         cv_seen = 0, err_seen = 0;

    onehot8_encoder #(.STABLE_CYCLES(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
        .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
        .sample_en(sample_en),
        .a(a), .b(b), .c(c),
        .code_valid(code_valid), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_onehot(input logic [7:0] p);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(p[i]);
        return ones == 1;
    endfunction

    function automatic logic [2:0] index_of(input logic [7:0] p);
        logic [2:0] idx = 3'd0;
        for (int i = 0; i < 8; i++) if (p[i]) idx = 3'(i);
        return idx;
    endfunction

    // One clock: drive on the falling edge, update the model at the rising edge, sample 1 ns later.
    task automatic cycle(input logic [7:0] p, input logic se, input logic r);
        @(negedge clk);
        y = p; sample_en = se; rst = r;
        @(posedge clk);
        m_cv = 0; m_err = 0;
        if (r) begin
            m_run = 0; m_prev = 8'd0; m_abc = 3'd0; m_locked = 0; m_cnt = 0;
        end else if (se) begin
            if (p == 8'd0)         m_run = 0;
            else if (p == m_prev)  m_run = (m_run < 100) ? m_run + 1 : m_run;
            else                   m_run = 1;
            m_prev = p;
            if (m_run == N) begin
                if (is_onehot(p)) begin
                    m_cv  = 1;
                    m_abc = index_of(p);
                end else begin
                    m_err = 1;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end
            m_locked = is_onehot(p) && (m_run >= N);
        end
        #1;
        cv_seen  += int'(code_valid);
        err_seen += int'(err);
        check("code_valid", 32'(code_valid), 32'(m_cv));
        check("err",        32'(err),        32'(m_err));
        check("locked",     32'(locked),     32'(m_locked));
        check("abc",        32'({a, b, c}),  32'(m_abc));
        check("err_cnt",    32'(err_cnt),    CNT_EN ? 32'(m_cnt) : 32'd0);
        check("no_overlap", 32'(code_valid && err), 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        int         sel;

        // Reset with a hostile input pattern.
        cycle(8'hFF, 1'b1, 1'b1);
        cycle(8'hFF, 1'b1, 1'b1);
        check("reset_all_zero", 32'({a, b, c, code_valid, locked, err}), 32'd0);
        check("reset_cnt", 32'(err_cnt), 32'd0);

        // Sweep of every one-hot code, each held for three samples.
        cv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) cycle(8'(1 << i), 1'b1, 1'b0);
            check("sweep_abc", 32'({a, b, c}), 32'(i));
        end
        check("sweep_pulses", 32'(cv_seen), 32'd8);

        // Glitch: single sample of 0x04 then 0x10 held.
        cycle(8'h00, 1'b1, 1'b0);
        cv_seen = 0;
        cycle(8'h04, 1'b1, 1'b0);
        cycle(8'h10, 1'b1, 1'b0);
        cycle(8'h10, 1'b1, 1'b0);
        check("glitch_abc", 32'({a, b, c}), 32'd4);
        cycle(8'h10, 1'b1, 1'b0);
        check("glitch_pulses", 32'(cv_seen), 32'd1);

        // Error pattern held, then a valid code.
        cycle(8'h00, 1'b1, 1'b1);
        err_seen = 0;
        for (int k = 0; k < 4; k++) cycle(8'h05, 1'b1, 1'b0);
        check("err_pulses", 32'(err_seen), 32'd1);
        check("err_cnt_one", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
        for (int k = 0; k < 3; k++) cycle(8'h02, 1'b1, 1'b0);
        check("after_err_abc", 32'({a, b, c}), 32'd1);

        // Saturation: 260 BAD acceptances separated by zero samples.
        err_seen = 0;
        for (int k = 0; k < 260; k++) begin
            cycle(8'h03, 1'b1, 1'b0);
            cycle(8'h03, 1'b1, 1'b0);
            cycle(8'h00, 1'b1, 1'b0);
        end
        check("sat_pulses", 32'(err_seen), 32'd260);
        check("sat_cnt", 32'(err_cnt), CNT_EN ? 32'(CMAX) : 32'd0);

        // Gaps inside a run, then a reset between the two samples.
        cycle(8'h80, 1'b1, 1'b0);
        cycle(8'h80, 1'b0, 1'b0);
        cycle(8'h80, 1'b0, 1'b0);
        cycle(8'h80, 1'b1, 1'b0);
        check("gap_accept", 32'({code_valid, a, b, c}), 32'b1111);
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h40, 1'b1, 1'b0);
        cycle(8'h40, 1'b0, 1'b1);
        cycle(8'h40, 1'b1, 1'b0);
        check("reset_breaks_run", 32'({code_valid, locked}), 32'd0);

        // Random traffic: repeats dominate so runs complete often.
        pat = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 5)      pat = 8'h00;
            else if (sel == 6 || sel == 7) pat = 8'(1 << $urandom_range(0, 7));
            else if (sel == 8) pat = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
            else if (sel == 9) pat = 8'($urandom);
            cycle(pat, $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
